bsx_stream_arb: RTL

- Arbitrates the two BS-X satellite stream channels (stream 0 at 2188-218d, stream 1 at 218e-2193) for a single byte-wide memory read port that holds the packet page data.
- Each channel keeps a one-byte prefetch buffer, tagged with its {page, offset}, so SNES register reads are served with zero wait.
- Sits between the BS-X register block (page/offset producer) and the memory arbiter.

---
 rtl/bsx_arb_pkg.sv | 25 ++
 rtl/bsx_stream_arb_if.sv | 10 +
 rtl/bsx_stream_buf.sv | 65 ++++++
 rtl/bsx_stream_arb.sv | 141 ++++++++++++++
 4 files changed

// File: rtl/bsx_arb_pkg.sv
// Shared types, widths and address composition for the BS-X stream arbiter.
package bsx_arb_pkg;

  localparam int NUM_CH = 2;
  localparam int PAGE_W = 10;
  localparam int OFS_W  = 9;
  localparam int TAG_W  = PAGE_W + OFS_W;

  typedef logic [1:0] buf_state_t;
  localparam buf_state_t BUF_EMPTY   = 2'd0;
  localparam buf_state_t BUF_PENDING = 2'd1;
  localparam buf_state_t BUF_FULL    = 2'd2;

  typedef logic [0:0] arb_state_t;
  localparam arb_state_t ARB_IDLE  = 1'b0;
  localparam arb_state_t ARB_ISSUE = 1'b1;

  // {page, offset} is zero-extended and added to the base with 24-bit wrap
  function automatic logic [23:0] compose_addr(input logic [23:0] base,
                                               input logic [PAGE_W-1:0] page,
                                               input logic [OFS_W-1:0] ofs);
    return base + {{(24 - TAG_W){1'b0}}, page, ofs};
  endfunction

endpackage

// File: rtl/bsx_stream_arb_if.sv
// Byte-wide memory read port shared by both stream channels.
interface bsx_stream_arb_if;
  logic        req;
  logic [23:0] addr;
  logic        ack;
  logic [7:0]  rdata;

  modport master (output req, addr, input ack, rdata);
  modport slave  (input req, addr, output ack, rdata);
endinterface

// File: rtl/bsx_stream_buf.sv
// One-byte prefetch buffer for a stream channel, tagged with {page, offset}.
//
// state       | meaning
// BUF_EMPTY   | no data; requests a fetch while valid
// BUF_PENDING | granted, waiting for the memory ack
// BUF_FULL    | holds the byte fetched for the tag
module bsx_stream_buf
  import bsx_arb_pkg::*;
(
  input  logic              clkin,
  input  logic              rst_n,
  input  logic              grant,
  input  logic              ack,
  input  logic              timeout,
  input  logic [7:0]        rdata,
  input  logic              consume,
  input  logic              valid,
  input  logic [PAGE_W-1:0] page,
  input  logic [OFS_W-1:0]  offset,
  output logic              empty,
  output logic              ready,
  output logic [7:0]        data
);

  buf_state_t       state;
  logic [TAG_W-1:0] tag;
  logic             match;

  assign match = (tag == {page, offset});
  assign empty = (state == BUF_EMPTY);
  assign ready = (state == BUF_FULL) && match;

  always_ff @(posedge clkin or negedge rst_n) begin
    if (!rst_n) begin
      state <= BUF_EMPTY;
      tag   <= '0;
      data  <= 8'h00;
    end else begin
      case (state)
        BUF_EMPTY: begin
          if (grant) begin
            state <= BUF_PENDING;
            tag   <= {page, offset};
          end
        end
        BUF_PENDING: begin
          // a watchdog expiry stands in for the ack with a filler byte
          if (ack || timeout) begin
            if (valid && match) begin
              state <= BUF_FULL;
              data  <= ack ? rdata : 8'hFF;
            end else begin
              state <= BUF_EMPTY;
            end
          end
        end
        BUF_FULL: begin
          if (consume || !match || !valid) state <= BUF_EMPTY;
        end
        default: state <= BUF_EMPTY;
      endcase
    end
  end

endmodule

// File: rtl/bsx_stream_arb.sv
// Round-robin arbiter of the two BS-X stream prefetch buffers onto one read port.
// Optional ack watchdog enabled with BSX_ARB_TIMEOUT_EN.
//
// state     | meaning
// ARB_IDLE  | pick an EMPTY, valid channel and latch its address
// ARB_ISSUE | hold mem req/addr until ack (or watchdog expiry)
module bsx_stream_arb
  import bsx_arb_pkg::*;
#(
  parameter logic [23:0] BASE_ADDR      = 24'hE00000,
  parameter int          TIMEOUT_CYCLES = 255
)
(
  input  logic                    clkin,
  input  logic                    rst_n,
  input  logic                    ch0_valid,
  input  logic                    ch1_valid,
  input  logic [PAGE_W-1:0]       ch0_page,
  input  logic [PAGE_W-1:0]       ch1_page,
  input  logic [OFS_W-1:0]        ch0_offset,
  input  logic [OFS_W-1:0]        ch1_offset,
  input  logic                    ch0_consume,
  input  logic                    ch1_consume,
  output logic [7:0]              ch0_data,
  output logic [7:0]              ch1_data,
  output logic                    ch0_ready,
  output logic                    ch1_ready,
  bsx_stream_arb_if.master        mem,
  output logic                    err_timeout
);

  arb_state_t        state;
  logic              req_q;
  logic [23:0]       addr_q;
  logic              gnt_ch;
  logic              last_gnt;
  logic [NUM_CH-1:0] valid_v;
  logic [NUM_CH-1:0] empty_v;
  logic [NUM_CH-1:0] cand;
  logic [NUM_CH-1:0] grant;
  logic [NUM_CH-1:0] ack_v;
  logic [NUM_CH-1:0] tmo_v;
  logic              sel;
  logic              issue;
  logic              tmo;
  logic [23:0]       sel_addr;

  assign valid_v = {ch1_valid, ch0_valid};
  assign cand    = valid_v & empty_v;
  assign issue   = (state == ARB_ISSUE);

  // a tie goes to the channel that was not granted last
  assign sel      = cand[1] & (~cand[0] | ~last_gnt);
  assign grant    = (!issue && |cand) ? (sel ? 2'b10 : 2'b01) : 2'b00;
  assign sel_addr = sel ? compose_addr(BASE_ADDR, ch1_page, ch1_offset)
                        : compose_addr(BASE_ADDR, ch0_page, ch0_offset);

  assign ack_v = (issue && mem.ack) ? (gnt_ch ? 2'b10 : 2'b01) : 2'b00;
  assign tmo_v = tmo ? (gnt_ch ? 2'b10 : 2'b01) : 2'b00;

  assign mem.req  = req_q;
  assign mem.addr = addr_q;

  always_ff @(posedge clkin or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ARB_IDLE;
      req_q    <= 1'b0;
      addr_q   <= '0;
      gnt_ch   <= 1'b0;
      last_gnt <= 1'b1;
    end else if (!issue) begin
      if (|cand) begin
        state    <= ARB_ISSUE;
        req_q    <= 1'b1;
        addr_q   <= sel_addr;
        gnt_ch   <= sel;
        last_gnt <= sel;
      end
    end else if (mem.ack || tmo) begin
      state <= ARB_IDLE;
      req_q <= 1'b0;
    end
  end

`ifdef BSX_ARB_TIMEOUT_EN
  logic [7:0] tmo_cnt;
  logic       err_q;

  assign tmo         = issue && !mem.ack && (tmo_cnt == 8'(TIMEOUT_CYCLES - 1));
  assign err_timeout = err_q;

  always_ff @(posedge clkin or negedge rst_n) begin
    if (!rst_n) begin
      tmo_cnt <= 8'h00;
      err_q   <= 1'b0;
    end else begin
      tmo_cnt <= issue ? tmo_cnt + 8'h01 : 8'h00;
      if (tmo) err_q <= 1'b1;
    end
  end
`else
  logic [31:0] unused_tmo_cfg;

  assign unused_tmo_cfg = TIMEOUT_CYCLES;
  assign tmo            = 1'b0;
  assign err_timeout    = 1'b0;
`endif

  bsx_stream_buf u_buf0 (
    .clkin   (clkin),
    .rst_n   (rst_n),
    .grant   (grant[0]),
    .ack     (ack_v[0]),
    .timeout (tmo_v[0]),
    .rdata   (mem.rdata),
    .consume (ch0_consume),
    .valid   (ch0_valid),
    .page    (ch0_page),
    .offset  (ch0_offset),
    .empty   (empty_v[0]),
    .ready   (ch0_ready),
    .data    (ch0_data)
  );

  bsx_stream_buf u_buf1 (
    .clkin   (clkin),
    .rst_n   (rst_n),
    .grant   (grant[1]),
    .ack     (ack_v[1]),
    .timeout (tmo_v[1]),
    .rdata   (mem.rdata),
    .consume (ch1_consume),
    .valid   (ch1_valid),
    .page    (ch1_page),
    .offset  (ch1_offset),
    .empty   (empty_v[1]),
    .ready   (ch1_ready),
    .data    (ch1_data)
  );

endmodule
